multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 81 ++++++++
 rtl/multicycle_controller_alu_decoder.sv | 49 ++++
 rtl/multicycle_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, ALU/immediate codes
// and datapath mux selects.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMREAD,
    ST_MEMWB,
    ST_MEMWRITE,
    ST_EXECR,
    ST_EXECI,
    ST_ALUWB,
    ST_BRANCH,
    ST_JAL,
    ST_JALR,
    ST_JALR2,
    ST_LUIWB,
    ST_TRAP
  } state_t;

  // Which rule set the ALU decoder applies in the current state.
  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_R,
    CLS_I,
    CLS_BRANCH
  } alu_class_t;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_OPIMM  = 7'd19;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_OP     = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMM       = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // DECODE precomputes the branch/jump target, so only B and J differ from the I default.
  function automatic logic [2:0] decode_imm_src(input logic [6:0] op);
    case (op)
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from instruction class and function fields; flags encodings that
// have no defined operation so the FSM can divert to TRAP.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  alu_class_t alu_class,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [2:0] alu_control,
  output logic       invalid
);

  always_comb begin
    alu_control = ALU_ADD;
    invalid     = 1'b0;
    case (alu_class)
      CLS_R: begin
        case ({func7, func3})
          10'd0:   alu_control = ALU_ADD;
          10'd256: alu_control = ALU_SUB;
          10'd6:   alu_control = ALU_OR;
          10'd7:   alu_control = ALU_AND;
          10'd2:   alu_control = ALU_SLT;
          10'd3:   alu_control = ALU_SLTU;
          default: invalid = 1'b1;
        endcase
      end
      CLS_I: begin
        case (func3)
          3'b000:  alu_control = ALU_ADD;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          default: invalid = 1'b1;
        endcase
      end
      CLS_BRANCH: begin
        alu_control = ALU_SUB;
        case (func3)
          F3_BEQ, F3_BNE, F3_BLT, F3_BGE: invalid = 1'b0;
          default:                        invalid = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM driving datapath enables and mux selects.
// Define MC_ILLEGAL_TRAP_EN to make TRAP sticky with illegal=1; otherwise TRAP is a one-cycle pass-through.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       lt,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       illegal
);

  state_t     state;
  state_t     state_next;
  alu_class_t alu_class;
  logic [2:0] alu_ctrl;
  logic       alu_invalid;
  logic       branch_taken;
  logic       pc_write_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       illegal_raw;

  always_comb begin
    case (state)
      ST_EXECR:  alu_class = CLS_R;
      ST_EXECI:  alu_class = CLS_I;
      ST_BRANCH: alu_class = CLS_BRANCH;
      default:   alu_class = CLS_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_class   (alu_class),
    .func3       (func3),
    .func7       (func7),
    .alu_control (alu_ctrl),
    .invalid     (alu_invalid)
  );

  always_comb begin
    case (func3)
      F3_BEQ:  branch_taken = zero;
      F3_BNE:  branch_taken = ~zero;
      F3_BLT:  branch_taken = lt;
      F3_BGE:  branch_taken = ~lt;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: state_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = ST_MEMADR;
          OP_OP:             state_next = ST_EXECR;
          OP_OPIMM:          state_next = ST_EXECI;
          OP_BRANCH:         state_next = ST_BRANCH;
          OP_JAL:            state_next = ST_JAL;
          OP_JALR:           state_next = ST_JALR;
          OP_LUI:            state_next = ST_LUIWB;
          default:           state_next = ST_TRAP;
        endcase
      end
      ST_MEMADR:          state_next = (opcode == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD:         state_next = ST_MEMWB;
      ST_EXECR, ST_EXECI: state_next = alu_invalid ? ST_TRAP : ST_ALUWB;
      ST_BRANCH:          state_next = alu_invalid ? ST_TRAP : ST_FETCH;
      ST_JAL, ST_JALR2:   state_next = ST_ALUWB;
      ST_JALR:            state_next = ST_JALR2;
      ST_MEMWB, ST_MEMWRITE, ST_ALUWB, ST_LUIWB: state_next = ST_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      ST_TRAP:            state_next = ST_TRAP;
`else
      ST_TRAP:            state_next = ST_FETCH;
`endif
      default:            state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    ImmSrc        = IMM_I;
    case (state)
      ST_FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
      end
      ST_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = decode_imm_src(opcode);
      end
      ST_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (opcode == OP_LOAD) ? IMM_I : IMM_S;
      end
      ST_MEMREAD: AdrSrc = 1'b1;
      ST_MEMWB: begin
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
      end
      ST_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      ST_EXECR: ALUSrcA = SRCA_RS1;
      ST_EXECI, ST_JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      ST_ALUWB: reg_write_raw = 1'b1;
      ST_BRANCH: begin
        ALUSrcA      = SRCA_RS1;
        pc_write_raw = branch_taken;
      end
      ST_JAL, ST_JALR2: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        pc_write_raw = 1'b1;
      end
      ST_LUIWB: begin
        ImmSrc        = IMM_U;
        ResultSrc     = RES_IMM;
        reg_write_raw = 1'b1;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      ST_TRAP: illegal_raw = 1'b1;
`endif
      default: illegal_raw = 1'b0;
    endcase
  end

  // ALU op is add outside EXECR/EXECI/BRANCH because the decoder's default class is add.
  assign ALUControl = alu_ctrl;

  // Architectural side effects are suppressed while reset is held, whatever the state.
  assign PCWrite  = pc_write_raw  & ~rst;
  assign MemWrite = mem_write_raw & ~rst;
  assign IRWrite  = ir_write_raw  & ~rst;
  assign RegWrite = reg_write_raw & ~rst;
  assign illegal  = illegal_raw   & ~rst;

endmodule
